// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage interlocked pipeline: tracks EX/MEM/WB
// destination registers and raises hold, flush and freeze controls for ID.
module pipeline_hazard_ctrl #(
    parameter bit CHECK_WB = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_use_i,
    input  logic             id_rs2_use_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_rf_we_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    output logic             pc_hold_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             pipe_freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_FLUSH,
        MODE_FREEZE
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Entry 0 = EX, 1 = MEM, 2 = WB
    sb_entry_t [2:0]  sb_q, sb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [2:0]       hit;
    logic             raw;
    mode_e            mode;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hit
            assign hit[gi] = sb_q[gi].valid & sb_q[gi].we & (sb_q[gi].rd != 5'd0) &
                             ((id_rs1_use_i & (id_rs1_i == sb_q[gi].rd)) |
                              (id_rs2_use_i & (id_rs2_i == sb_q[gi].rd)));
        end
    endgenerate

    assign raw = id_valid_i & (hit[0] | hit[1] | (CHECK_WB & hit[2]));

    always_comb begin
        mode = MODE_RUN;
        if (!rst_n_i)           mode = MODE_RUN;
        else if (mem_busy_i)    mode = MODE_FREEZE;
        else if (ex_redirect_i) mode = MODE_FLUSH;
        else if (raw)           mode = MODE_STALL;
    end

    always_comb begin
        pc_hold_o     = 1'b0;
        ifid_hold_o   = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        pipe_freeze_o = 1'b0;
        case (mode)
            MODE_FREEZE: begin
                pipe_freeze_o = 1'b1;
                pc_hold_o     = 1'b1;
                ifid_hold_o   = 1'b1;
            end
            MODE_FLUSH: begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end
            MODE_STALL: begin
                pc_hold_o    = 1'b1;
                ifid_hold_o  = 1'b1;
                idex_flush_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        sb_d        = sb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (mode != MODE_FREEZE) begin
            sb_d[2] = sb_q[1];
            sb_d[1] = sb_q[0];
            // A stalled or flushed ID instruction enters EX as a bubble
            sb_d[0] = '0;
            if (mode == MODE_RUN) sb_d[0] = {id_valid_i, id_rf_we_i, id_rd_i};
        end
        if (mode == MODE_STALL && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (mode == MODE_FLUSH && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall and flush sequencer for the 5-stage stall-based pipeline; no forwarding is used. It keeps an internal scoreboard of destination registers for the instructions in EX, MEM and WB. It compares these against the source registers of the instruction in ID, using the per-operand hazard-detect enables produced by the decode controller. It generates PC/IF-ID hold, IF-ID/ID-EX flush and whole-pipe freeze controls, and counts stall and flush cycles for on-board debug.

## Interface
Parameters:
- CHECK_WB, 1: 1 = regfile is not write-through, so a producer in WB still blocks a reader; 0 = WB is excluded from the comparison.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_i  in  1  pipeline clock
- rst_n_i  in  1  reset, asynchronous and active-low
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i / id_rs2_i  in  5  ID source register indices
- id_rs1_use_i / id_rs2_use_i  in  1  ID actually reads rs1/rs2 (the decode hazard-detect enables)
- id_rd_i  in  5  ID destination register
- id_rf_we_i  in  1  ID writes the regfile
- ex_redirect_i  in  1  EX instruction redirects the PC (taken branch, jal, jalr)
- mem_busy_i  in  1  data memory not ready; freeze the whole pipe
- pc_hold_o  out  1  PC keeps its value
- ifid_hold_o  out  1  IF/ID register keeps its value
- ifid_flush_o  out  1  IF/ID loads a bubble
- idex_flush_o  out  1  ID/EX loads a bubble
- pipe_freeze_o  out  1  ID/EX, EX/MEM and MEM/WB hold; regfile and memory writes are suppressed
- stall_cnt_o  out  CNT_W  data-hazard stall cycles since reset
- flush_cnt_o  out  CNT_W  flush cycles since reset

## Operation
Scoreboard:
- Three entries, EX, MEM and WB. Each entry is {valid, we, rd[4:0]}.
- Reset clears every entry to 0.

Hazard detection:
- hit(s) = s.valid & s.we & (s.rd != 0) & ((id_rs1_use_i & id_rs1_i == s.rd) | (id_rs2_use_i & id_rs2_i == s.rd)).
- raw = id_valid_i & (hit(EX) | hit(MEM) | (CHECK_WB & hit(WB))).
- x0 never produces a hazard.

Mode selection, in priority order (combinational, evaluated each cycle):
1. FREEZE (mem_busy_i = 1): pipe_freeze_o = 1, pc_hold_o = 1, ifid_hold_o = 1, both flushes 0. All scoreboard entries hold. No counter increments.
2. FLUSH (ex_redirect_i = 1): ifid_flush_o = 1, idex_flush_o = 1, both holds 0. Any raw is ignored because the ID instruction is discarded. flush_cnt_o increments.
3. STALL (raw = 1): pc_hold_o = 1, ifid_hold_o = 1, idex_flush_o = 1. stall_cnt_o increments.
4. RUN: all outputs 0.

Scoreboard update on each clock edge, unless the mode is FREEZE:
- WB <= MEM and MEM <= EX.
- EX <= {0,0,0} in FLUSH or STALL.
- Otherwise EX <= {id_valid_i, id_rf_we_i, id_rd_i}.

Counters:
- Unsigned; they saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from the scoreboard and the current inputs, with zero-cycle latency.
- The scoreboard and counters are registered on the rising edge of clk_i.
- While rst_n_i = 0:
  - Scoreboard and counters are cleared immediately (asynchronously).
  - All control outputs are forced to 0; inputs are ignored.
- Deasserting reset mid-stall returns the block to RUN with an empty scoreboard.
- Stall length for a consumer directly behind its producer (distance 1): 3 cycles with CHECK_WB = 1, 2 cycles with CHECK_WB = 0. Distance 2 gives 2/1 cycles; distance 3 gives 1/0 cycles.
- Redirect arriving while ID is stalling: the flush wins in that cycle, and the stall ends with no extra bubble.
- mem_busy_i asserted mid-stall: the stall is suspended, not consumed. The remaining stall cycles resume once busy drops.
- A self-dependency in ID (rd equal to rs1) is not a hazard; only EX, MEM and WB entries are compared.

## Test plan
- Reset: hold rst_n_i low, drive random inputs -> all outputs 0 and counters 0. Release reset, issue an add with no dependency -> RUN with no holds.
- RAW distance 1: issue add x5,.. then add x6,x5,x1 (rs1_use = 1) -> with CHECK_WB = 1, exactly 3 cycles of pc_hold/ifid_hold/idex_flush, then RUN, and stall_cnt_o = 3. With CHECK_WB = 0 -> 2 cycles.
- Disabled operand and x0: producer writes x5, consumer has rs2 = x5 but rs2_use = 0 -> no stall. Producer writes x0, consumer reads x0 -> no stall.
- Redirect during stall: start a distance-1 RAW, then assert ex_redirect_i in the first stall cycle -> ifid_flush/idex_flush = 1 and pc_hold = 0 in that cycle. flush_cnt_o = 1, stall_cnt_o = 0. EX entry is a bubble on the next cycle.
- Freeze: assert mem_busy_i for 4 cycles during the second cycle of a 3-cycle stall -> pipe_freeze_o = 1 for 4 cycles with counters unchanged. After release, exactly 2 more stall cycles follow, for a total stall_cnt_o of 3.
- Saturation: with CNT_W = 4, force more than 20 stall cycles -> stall_cnt_o holds at 15.
